// File: rtl/gfx128_wbm_read_arbiter_if.sv
// Bundle of requester-side (z, tex, blend) and reader-side signals for the
// 128-bit wishbone read arbiter; slave = arbiter view, master = environment.
interface gfx128_wbm_read_arbiter_if #(
   parameter int ADDR_LSB = 4
);
   logic                z_request_i;
   logic [31:ADDR_LSB]  z_addr_i;
   logic [15:0]         z_sel_i;
   logic                z_ack_o;
   logic [127:0]        z_data_o;
   logic                z_busy_o;

   logic                tex_request_i;
   logic [31:ADDR_LSB]  tex_addr_i;
   logic [15:0]         tex_sel_i;
   logic                tex_ack_o;
   logic [127:0]        tex_data_o;
   logic                tex_busy_o;

   logic                blend_request_i;
   logic [31:ADDR_LSB]  blend_addr_i;
   logic [15:0]         blend_sel_i;
   logic                blend_ack_o;
   logic [127:0]        blend_data_o;
   logic                blend_busy_o;

   logic                m_request_o;
   logic [31:ADDR_LSB]  m_addr_o;
   logic [15:0]         m_sel_o;
   logic                m_ack_i;
   logic [127:0]        m_data_i;
   logic                m_busy_i;

   modport slave (
      input  z_request_i, z_addr_i, z_sel_i,
      output z_ack_o, z_data_o, z_busy_o,
      input  tex_request_i, tex_addr_i, tex_sel_i,
      output tex_ack_o, tex_data_o, tex_busy_o,
      input  blend_request_i, blend_addr_i, blend_sel_i,
      output blend_ack_o, blend_data_o, blend_busy_o,
      output m_request_o, m_addr_o, m_sel_o,
      input  m_ack_i, m_data_i, m_busy_i
   );

   modport master (
      output z_request_i, z_addr_i, z_sel_i,
      input  z_ack_o, z_data_o, z_busy_o,
      output tex_request_i, tex_addr_i, tex_sel_i,
      input  tex_ack_o, tex_data_o, tex_busy_o,
      output blend_request_i, blend_addr_i, blend_sel_i,
      input  blend_ack_o, blend_data_o, blend_busy_o,
      input  m_request_o, m_addr_o, m_sel_o,
      output m_ack_i, m_data_i, m_busy_i
   );
endinterface

// File: rtl/gfx128_wbm_read_arbiter.sv
// Three-way (z/tex/blend) arbiter in front of one 128-bit wishbone read master.
// Fixed priority z > tex > blend by default; define GFX128_RR_ARB_EN for round-robin.
module gfx128_wbm_read_arbiter #(
   parameter int ADDR_LSB = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   gfx128_wbm_read_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ACTIVE  = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [1:0] ID_Z     = 2'd0;
   localparam logic [1:0] ID_TEX   = 2'd1;
   localparam logic [1:0] ID_BLEND = 2'd2;

   logic [2:0]          req;
   logic [31:ADDR_LSB]  addr_in [3];
   logic [15:0]         sel_in  [3];

   assign req        = {bus.blend_request_i, bus.tex_request_i, bus.z_request_i};
   assign addr_in[0] = bus.z_addr_i;
   assign addr_in[1] = bus.tex_addr_i;
   assign addr_in[2] = bus.blend_addr_i;
   assign sel_in[0]  = bus.z_sel_i;
   assign sel_in[1]  = bus.tex_sel_i;
   assign sel_in[2]  = bus.blend_sel_i;

   logic [1:0]          state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic [31:ADDR_LSB]  addr_q, addr_d;
   logic [15:0]         sel_q, sel_d;
   logic [2:0]          ack_q, ack_d;
   logic [127:0]        data_q [3];
   logic                grant;
   logic [1:0]          winner;

   // First requesting index found when scanning upward from 'first' with wrap.
   function automatic logic [1:0] pick_winner(input logic [2:0] reqs,
                                              input logic [1:0] first);
      logic [1:0] cand;
      logic [1:0] win;
      logic       found;
      cand  = first;
      win   = first;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (!found && reqs[cand]) begin
            win   = cand;
            found = 1'b1;
         end
         cand = (cand == ID_BLEND) ? ID_Z : cand + 2'd1;
      end
      return win;
   endfunction

   assign grant = (state_q == ST_IDLE) && (|req) && !bus.m_busy_i;

`ifdef GFX128_RR_ARB_EN
   // Holds the first candidate of the next search (the one after the last grant).
   logic [1:0] rr_ptr_q;

   assign winner = pick_winner(req, rr_ptr_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= ID_Z;
      end else if (grant) begin
         rr_ptr_q <= (winner == ID_BLEND) ? ID_Z : winner + 2'd1;
      end
   end
`else
   assign winner = pick_winner(req, ID_Z);
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      ack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_ACTIVE;
               owner_d = winner;
               addr_d  = addr_in[winner];
               sel_d   = sel_in[winner];
            end
         end
         ST_ACTIVE: begin
            if (bus.m_ack_i) begin
               state_d        = ST_RELEASE;
               ack_d[owner_q] = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= ID_Z;
         addr_q  <= '0;
         sel_q   <= '0;
         ack_q   <= '0;
         for (int n = 0; n < 3; n++) data_q[n] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         for (int n = 0; n < 3; n++) begin
            if (ack_d[n]) data_q[n] <= bus.m_data_i;
         end
      end
   end

   logic in_txn;
   assign in_txn = (state_q != ST_IDLE);

   assign bus.m_request_o  = (state_q == ST_ACTIVE);
   assign bus.m_addr_o     = addr_q;
   assign bus.m_sel_o      = sel_q;

   assign bus.z_ack_o      = ack_q[0];
   assign bus.tex_ack_o    = ack_q[1];
   assign bus.blend_ack_o  = ack_q[2];
   assign bus.z_data_o     = data_q[0];
   assign bus.tex_data_o   = data_q[1];
   assign bus.blend_data_o = data_q[2];

   assign bus.z_busy_o     = in_txn && (owner_q != ID_Z);
   assign bus.tex_busy_o   = in_txn && (owner_q != ID_TEX);
   assign bus.blend_busy_o = in_txn && (owner_q != ID_BLEND);

endmodule

// File: tb/tb_gfx128_wbm_read_arbiter.sv
// Self-checking bench for gfx128_wbm_read_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level ownership model.
module tb_gfx128_wbm_read_arbiter;
   localparam int ADDR_LSB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gfx128_wbm_read_arbiter_if #(.ADDR_LSB(ADDR_LSB)) bus ();

   gfx128_wbm_read_arbiter #(.ADDR_LSB(ADDR_LSB)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Stimulus registers
   logic         req_drv  [3];
   logic [27:0]  addr_drv [3];
   logic [15:0]  sel_drv  [3];
   logic         m_ack    = 1'b0;
   logic         m_busy   = 1'b0;
   logic [127:0] m_data   = '0;

   assign bus.z_request_i     = req_drv[0];
   assign bus.tex_request_i   = req_drv[1];
   assign bus.blend_request_i = req_drv[2];
   assign bus.z_addr_i        = addr_drv[0];
   assign bus.tex_addr_i      = addr_drv[1];
   assign bus.blend_addr_i    = addr_drv[2];
   assign bus.z_sel_i         = sel_drv[0];
   assign bus.tex_sel_i       = sel_drv[1];
   assign bus.blend_sel_i     = sel_drv[2];
   assign bus.m_ack_i         = m_ack;
   assign bus.m_busy_i        = m_busy;
   assign bus.m_data_i        = m_data;

   // Reference model: who owns the reader, whether it is in its release cycle,
   // which requester is being acknowledged, and the data each requester should hold.
   int           own     = -1;
   bit           rel     = 1'b0;
   int           ptr     = 0;
   int           ack_who = -1;
   logic [27:0]  maddr   = '0;
   logic [15:0]  msel    = '0;
   logic [127:0] mdata [3] = '{default: '0};

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int pick();
      int start;
`ifdef GFX128_RR_ARB_EN
      start = ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < 3; k++) begin
         if (req_drv[(start + k) % 3]) return (start + k) % 3;
      end
      return -1;
   endfunction

   task automatic model_update();
      int w;
      if (rst) begin
         own = -1; rel = 1'b0; ptr = 0; ack_who = -1;
         maddr = '0; msel = '0;
         for (int n = 0; n < 3; n++) mdata[n] = '0;
      end else if (own < 0) begin
         ack_who = -1;
         w = pick();
         if (w >= 0 && !m_busy) begin
            own   = w;
            maddr = addr_drv[w];
            msel  = sel_drv[w];
            ptr   = (w + 1) % 3;
         end
      end else if (!rel) begin
         ack_who = -1;
         if (m_ack) begin
            mdata[own] = m_data;
            ack_who    = own;
            rel        = 1'b1;
         end
      end else begin
         own = -1; rel = 1'b0; ack_who = -1;
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model, then return
   // 1 ns after the rising edge so the caller can drive the next inputs.
   task automatic step();
      logic [2:0] exp_ack, exp_busy;
      @(negedge clk);
      exp_ack  = '0;
      exp_busy = '0;
      for (int n = 0; n < 3; n++) begin
         exp_ack[n]  = (ack_who == n);
         exp_busy[n] = (own >= 0) && (own != n);
      end
      check("m_request", bus.m_request_o, (own >= 0) && !rel);
      check("m_addr",    bus.m_addr_o, maddr);
      check("m_sel",     bus.m_sel_o, msel);
      check("acks",      {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, exp_ack);
      check("busys",     {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o}, exp_busy);
      check("z_data",     bus.z_data_o, mdata[0]);
      check("tex_data",   bus.tex_data_o, mdata[1]);
      check("blend_data", bus.blend_data_o, mdata[2]);
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      for (int n = 0; n < 3; n++) begin
         req_drv[n] = 1'b0; addr_drv[n] = '0; sel_drv[n] = '0;
      end
      m_ack = 1'b0; m_busy = 1'b0; m_data = '0;
   endtask

   task automatic apply_reset();
      quiet_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [27:0] exp_seq [4];
   int          grants;
   int          act_cnt;
   bit          prev_req;

   initial begin
      quiet_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      apply_reset();
      check("reset_m_request", bus.m_request_o, 1'b0);
      check("reset_m_addr",    bus.m_addr_o, 28'h0);
      check("reset_busy",      {bus.blend_busy_o, bus.tex_busy_o, bus.z_busy_o}, 3'b000);

      // Single z read, reader acks 5 cycles after the request appears
      req_drv[0] = 1'b1; addr_drv[0] = 28'h0001234; sel_drv[0] = 16'hFFFF;
      step();
      check("t1_m_request", bus.m_request_o, 1'b1);
      check("t1_m_addr",    bus.m_addr_o, 28'h0001234);
      check("t1_tex_busy",  bus.tex_busy_o, 1'b1);
      addr_drv[0] = 28'h0BADBAD;
      repeat (5) step();
      check("t1_addr_held", bus.m_addr_o, 28'h0001234);
      m_ack = 1'b1; m_data = {16{8'hA5}};
      step();
      m_ack = 1'b0; req_drv[0] = 1'b0;
      check("t1_z_ack",  bus.z_ack_o, 1'b1);
      check("t1_z_data", bus.z_data_o, {16{8'hA5}});
      check("t1_m_request_drop", bus.m_request_o, 1'b0);
      step();
      check("t1_z_ack_pulse", bus.z_ack_o, 1'b0);
      repeat (2) step();

      // All three held; grant order depends on arbitration mode
      apply_reset();
      for (int n = 0; n < 3; n++) begin
         req_drv[n] = 1'b1; addr_drv[n] = 28'(28'h100 * (n + 1)); sel_drv[n] = 16'(16'h1 << n);
      end
`ifdef GFX128_RR_ARB_EN
      exp_seq = '{28'h100, 28'h200, 28'h300, 28'h100};
`else
      exp_seq = '{28'h100, 28'h100, 28'h100, 28'h100};
`endif
      grants = 0; act_cnt = 0; prev_req = 1'b0;
      for (int cyc = 0; cyc < 200 && grants < 4; cyc++) begin
         if (bus.m_request_o && !prev_req) begin
            check($sformatf("t2_grant%0d", grants), bus.m_addr_o, exp_seq[grants]);
            grants++;
         end
         prev_req = bus.m_request_o;
         act_cnt  = (own >= 0 && !rel) ? act_cnt + 1 : 0;
         m_ack    = (act_cnt == 2);
         m_data   = {4{$urandom}};
         step();
      end
      check("t2_grant_count", grants, 4);
      quiet_inputs();
      repeat (4) step();

      // Reader occupied by another master for 10 cycles while tex waits
      apply_reset();
      m_busy = 1'b1;
      req_drv[1] = 1'b1; addr_drv[1] = 28'h0ABCDEF; sel_drv[1] = 16'h00F0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t3_blocked", bus.m_request_o, 1'b0);
      end
      m_busy = 1'b0;
      step();
      check("t3_grant", bus.m_request_o, 1'b1);
      check("t3_addr",  bus.m_addr_o, 28'h0ABCDEF);
      m_ack = 1'b1; m_data = {4{32'hC0FFEE11}};
      step();
      m_ack = 1'b0; req_drv[1] = 1'b0;
      check("t3_tex_ack", bus.tex_ack_o, 1'b1);
      repeat (2) step();

      // Reset in the middle of a blend read, then a stale reader ack
      apply_reset();
      req_drv[2] = 1'b1; addr_drv[2] = 28'h0000042; sel_drv[2] = 16'h000F;
      step();
      step();
      check("t4_active", bus.m_request_o, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0; req_drv[2] = 1'b0;
      m_ack = 1'b1; m_data = {4{32'hDEADBEEF}};
      step();
      m_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4_no_ack", {bus.blend_ack_o, bus.tex_ack_o, bus.z_ack_o}, 3'b000);
         check("t4_no_req", bus.m_request_o, 1'b0);
         step();
      end
      check("t4_blend_data", bus.blend_data_o, 128'h0);

      // Random traffic
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int n = 0; n < 3; n++) begin
            if (req_drv[n]) begin
               if (ack_who == n) begin
                  req_drv[n]  = 1'($urandom % 2);
                  addr_drv[n] = 28'($urandom);
                  sel_drv[n]  = 16'($urandom);
               end else if ($urandom % 16 == 0) begin
                  req_drv[n] = 1'b0;
               end else if (own == n && $urandom % 4 == 0) begin
                  addr_drv[n] = 28'($urandom);
               end
            end else if ($urandom % 4 == 0) begin
               req_drv[n]  = 1'b1;
               addr_drv[n] = 28'($urandom);
               sel_drv[n]  = 16'($urandom);
            end
         end
         m_ack  = ($urandom % 4 == 0);
         m_busy = ($urandom % 6 == 0);
         m_data = {$urandom, $urandom, $urandom, $urandom};
         rst    = ($urandom % 200 == 0);
         step();
      end
      rst = 1'b0;
      quiet_inputs();
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
